// File: rtl/uart_rx_mc.sv
// Oversampling UART receiver with majority-vote bit decisions and a small
// first-word-fall-through receive FIFO carrying per-frame error flags.
module uart_rx_mc #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_parity_err,
  output logic              rd_frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(DATA_W + 1);
  localparam int EW  = DATA_W + 2;

  localparam logic [OSW-1:0] SMP_A    = OSW'(OVERSAMPLE/2 - 1);
  localparam logic [OSW-1:0] SMP_B    = OSW'(OVERSAMPLE/2);
  localparam logic [OSW-1:0] SMP_C    = OSW'(OVERSAMPLE/2 + 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state, state_nxt;

  logic              rx_meta, rxs;
  logic [DIV_W-1:0]  div_q, div_cnt, div_last;
  logic [1:0]        pmode_q;
  logic              two_stop_q;
  logic [OSW-1:0]    os_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              s_a, s_b;
  logic              second_stop, parity_err, frame_err, wr_req;
  logic              start_det, tick, sample_a, sample_b, decide, bit_end;
  logic              maj, parity_en, final_stop, frame_err_nxt, end_frame;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, pop, push;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // A divisor of 0 behaves as 1, so the tick fires every cycle.
  assign div_last      = (div_q == '0) ? '0 : div_q - DIV_W'(1);
  assign start_det     = (state == IDLE) && !rxs;
  assign tick          = (state != IDLE) && (div_cnt == div_last);
  assign sample_a      = tick && (os_cnt == SMP_A);
  assign sample_b      = tick && (os_cnt == SMP_B);
  assign decide        = tick && (os_cnt == SMP_C);
  assign bit_end       = tick && (os_cnt == OS_LAST);
  assign maj           = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
  assign parity_en     = pmode_q[0] ^ pmode_q[1];
  assign final_stop    = !two_stop_q || second_stop;
  assign frame_err_nxt = frame_err | !maj;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rxs) state_nxt = START;
      START: begin
        if (decide && maj)  state_nxt = IDLE;
        else if (bit_end)   state_nxt = DATA;
      end
      DATA:      if (bit_end && bit_cnt == BCW'(DATA_W))
                   state_nxt = parity_en ? PARITY : STOP;
      PARITY:    if (bit_end) state_nxt = STOP;
      STOP:      if (decide && final_stop)
                   state_nxt = frame_err_nxt ? WAIT_IDLE : IDLE;
      WAIT_IDLE: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    end_frame = (state == STOP) && decide && final_stop;
  end

  // Frame datapath; the FIFO write request lands one cycle after the last decision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q       <= '0;
      pmode_q     <= '0;
      two_stop_q  <= 1'b0;
      div_cnt     <= '0;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      s_a         <= 1'b1;
      s_b         <= 1'b1;
      second_stop <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      wr_req      <= 1'b0;
    end else begin
      wr_req <= end_frame;
      if (start_det) begin
        div_q       <= divisor;
        pmode_q     <= parity_mode;
        two_stop_q  <= two_stop;
        div_cnt     <= '0;
        os_cnt      <= '0;
        bit_cnt     <= '0;
        second_stop <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
      end else if (state == IDLE) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OSW'(1);
        if (sample_a) s_a <= rxs;
        if (sample_b) s_b <= rxs;
        if (decide) begin
          case (state)
            DATA: begin
              shreg   <= {maj, shreg[DATA_W-1:1]};
              bit_cnt <= bit_cnt + BCW'(1);
            end
            PARITY:  parity_err <= (^shreg) ^ maj ^ pmode_q[1];
            STOP:    frame_err  <= frame_err_nxt;
            default: ;
          endcase
        end
        if (bit_end && state == STOP) second_stop <= 1'b1;
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && rd_ready;
  assign push  = wr_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      overrun <= wr_req && full && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr[AW-1:0]] <= {shreg, parity_err, frame_err};
  end

  always_comb begin
    rd_valid = !empty;
    {rd_data, rd_parity_err, rd_frame_err} = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_uart_rx_mc.sv
// Scoreboard bench for uart_rx_mc: frames are serialised on rx, expected FIFO
// entries are queued when driven and compared as the receiver pops them.
module tb_uart_rx_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] divisor;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        rd_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_parity_err;
  logic        rd_frame_err;
  logic        overrun;
  logic        busy;

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  int          ovr_cnt  = 0;
  logic [9:0]  exp_q[$];

  uart_rx_mc #(.DATA_W(8), .OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .divisor(divisor), .parity_mode(parity_mode),
    .two_stop(two_stop), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, away from the sampling edges.
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_clk(16 * ((divisor == 0) ? 1 : int'(divisor)));
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] pm, input logic pbit,
                               input logic two, input logic stop2, input logic [15:0] div,
                               input bit store);
    logic perr, ferr;
    perr = (pm == 2'b01) ? (^data ^ pbit) : (pm == 2'b10) ? ~(^data ^ pbit) : 1'b0;
    ferr = two && !stop2;
    if (store) exp_q.push_back({data, perr, ferr});
    divisor     = div;
    parity_mode = pm;
    two_stop    = two;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (pm == 2'b01 || pm == 2'b10) send_bit(pbit);
    send_bit(1'b1);
    if (two) send_bit(stop2);
  endtask

  always @(negedge clk) begin
    if (rst && overrun) ovr_cnt++;
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst && rd_valid && rd_ready) begin
      checkOutput("pending_expect", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("rd_data", 32'(rd_data), 32'(e[9:2]));
        checkOutput("rd_parity_err", 32'(rd_parity_err), 32'(e[1]));
        checkOutput("rd_frame_err", 32'(rd_frame_err), 32'(e[0]));
      end
    end
  end

  initial begin
    rst = 1'b0; rx = 1'b1; divisor = 16'd1; parity_mode = 2'b00;
    two_stop = 1'b0; rd_ready = 1'b1;
    wait_clk(5);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_rd_parity_err", 32'(rd_parity_err), 32'd0);
    checkOutput("rst_rd_frame_err", 32'(rd_frame_err), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    wait_clk(5);

    applyStimulus(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
    wait_clk(30);
    checkOutput("a5_drained", 32'(exp_q.size()), 32'd0);

    applyStimulus(8'h07, 2'b01, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
    wait_clk(20);
    applyStimulus(8'h07, 2'b01, 1'b1, 1'b0, 1'b1, 16'd1, 1'b1);
    wait_clk(30);
    checkOutput("parity_drained", 32'(exp_q.size()), 32'd0);

    // Bad second stop bit, then the line stays in break.
    applyStimulus(8'h3C, 2'b00, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1);
    wait_clk(200);
    checkOutput("break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_clk(5);
    checkOutput("break_released_busy", 32'(busy), 32'd0);
    wait_clk(20);
    checkOutput("break_drained", 32'(exp_q.size()), 32'd0);

    rx = 1'b0;
    wait_clk(4);
    checkOutput("glitch_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_clk(12);
    checkOutput("glitch_idle", 32'(busy), 32'd0);
    wait_clk(20);
    checkOutput("glitch_no_write", 32'(rd_valid), 32'd0);

    rd_ready = 1'b0;
    ovr_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 2'b00, 1'b0, 1'b0, 1'b1, 16'd1, i <= 4);
      if (i == 4) begin
        wait_clk(10);
        checkOutput("ovr_before_5", 32'(ovr_cnt), 32'd0);
      end
    end
    wait_clk(10);
    checkOutput("ovr_at_5", 32'(ovr_cnt), 32'd1);
    checkOutput("full_head_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    wait_clk(10);
    checkOutput("ovr_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("ovr_empty_after", 32'(rd_valid), 32'd0);

    // Reset in the middle of bit 3 of 0x55.
    divisor = 16'd1; parity_mode = 2'b00; two_stop = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    wait_clk(8);
    rst = 1'b0;
    wait_clk(4);
    rx = 1'b1;
    rst = 1'b1;
    wait_clk(30);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_no_write", 32'(rd_valid), 32'd0);
    applyStimulus(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
    wait_clk(30);
    checkOutput("midreset_drained", 32'(exp_q.size()), 32'd0);

    applyStimulus(8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1);
    wait_clk(60);
    checkOutput("div3_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("final_overrun_total", 32'(ovr_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_mc.md
UART_RX_MC -- requirements
Module: uart_rx_mc

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16: oversample ticks per bit, even, at least 8.
REQ-003 Parameter DIV_W, default 16: width of the divisor input.
REQ-004 Parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, at least 2.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 rx  in  1  asynchronous serial line, idle high.
REQ-008 divisor  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1.
REQ-009 parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
REQ-010 two_stop  in  1  1 = two stop bits checked.
REQ-011 rd_ready  in  1  consumer accepts the head FIFO entry.
REQ-012 rd_valid  out  1  FIFO non-empty.
REQ-013 rd_data  out  DATA_W  head entry data, LSB = first received bit.
REQ-014 rd_parity_err  out  1  head entry parity error flag.
REQ-015 rd_frame_err  out  1  head entry stop-bit error flag.
REQ-016 overrun  out  1  one-cycle pulse; a completed frame was dropped.
REQ-017 busy  out  1  receiver not in IDLE.

Function
REQ-018 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-019 The tick counter SHALL count 0..max(divisor,1)-1 and emit a one-cycle tick on wrap. It SHALL restart at 0 on start detection.
REQ-020 divisor, parity_mode and two_stop SHALL be latched on start detection and held constant for the frame.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-022 IDLE: rxs=0 SHALL enter START with the oversample counter at 0.
REQ-023 Each bit SHALL be decided by majority of 3 samples taken on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-024 START: a majority-1 result SHALL be a false start -> IDLE, with no FIFO write. A majority-0 result SHALL go to DATA after OVERSAMPLE ticks.
REQ-025 DATA: DATA_W bits shift in LSB first -> PARITY if parity is enabled, else STOP.
REQ-026 PARITY: parity_err = (XOR of data bits ^ parity bit) for even, inverted for odd -> STOP.
REQ-027 STOP: frame_err SHALL be set if any checked stop bit decides 0. The final stop bit's decision SHALL end the frame; the second stop bit is evaluated only when two_stop=1.
REQ-028 End of frame, frame_err=0: FIFO write {data, parity_err, frame_err} on the cycle after the decision -> IDLE.
REQ-029 End of frame, frame_err=1: same FIFO write -> WAIT_IDLE.
REQ-030 WAIT_IDLE SHALL hold until rxs=1 -> IDLE; a break does not produce further frames.
REQ-031 The FIFO SHALL be first-word-fall-through. A pop occurs when rd_valid & rd_ready. Pointers are log2(FIFO_DEPTH)+1 bits and wrap.
REQ-032 Write while full without a simultaneous pop: the frame SHALL be dropped, overrun pulses 1 cycle, and FIFO contents are unchanged.
REQ-033 Write while full with a simultaneous pop: both SHALL succeed and overrun stays 0.
REQ-034 Write and pop on an empty FIFO: the entry SHALL appear (rd_valid=1) the following cycle; no bypass.
REQ-035 rd_* outputs SHALL be registered/FIFO-driven; rd_data and flags are undefined-but-stable when rd_valid=0 (drive 0).

Reset
REQ-036 rst=0 SHALL force IDLE, clear FIFO pointers and counters, and set synchronizer flops to 1.
REQ-037 Reset values SHALL be: rd_valid=0, rd_data=0, rd_parity_err=0, rd_frame_err=0, overrun=0, busy=0.
REQ-038 Reset asserted mid-frame SHALL discard the partial frame; no FIFO write occurs.

Verification (DATA_W=8, OVERSAMPLE=16, divisor=1 so 1 bit = 16 clk, FIFO_DEPTH=4)
REQ-039 8N1 frame 0xA5, rd_ready=1 -> one rd_valid beat, rd_data=0xA5, both error flags 0.
REQ-040 parity_mode=01, data 0x07 with parity bit 0 -> rd_data=0x07, rd_parity_err=1. Same frame with parity bit 1 -> rd_parity_err=0.
REQ-041 two_stop=1, 0x3C with second stop bit 0 -> rd_frame_err=1. rx held 0 for 200 clk -> no further frames; busy=1 until rx=1.
REQ-042 rx low for 4 clk then high -> no FIFO write, busy returns to 0 by 16 clk.
REQ-043 Five frames 0x01..0x05 with rd_ready=0 -> overrun pulses once, at frame 5. Then rd_ready=1 -> reads 0x01,0x02,0x03,0x04 in order, then rd_valid=0.
REQ-044 rst=0 during bit 3 of frame 0x55, then a clean frame 0x81 -> only 0x81 received, no errors.
REQ-045 divisor=3, frame 0xFF -> bit period 48 clk, rd_data=0xFF.
